// File: rtl/mfp_clock_edge_monitor.sv
// Monitors a slow, asynchronous clock-like signal: synchronizes it, emits rise/fall strobes,
// measures the rise-to-rise period in clk cycles and flags a stopped source.
module mfp_clock_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned TIMEOUT     = 2**27
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sig_async,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             sig_sync,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  // Unarmed: no reference rise yet (after reset); Stalled: timed out, also unarmed.
  typedef enum logic [1:0] {
    StUnarmed,
    StArmed,
    StStalled
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_det;
  logic                   fall_det;
  logic                   rise_pulse_q;
  logic                   fall_pulse_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_hit;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_sync = sync_q[SYNC_STAGES-1];
  assign rise_det = sig_sync & ~prev_q;
  assign fall_det = ~sig_sync & prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
    end else begin
      rise_pulse_q <= rise_det;
      fall_pulse_q <= fall_det;
    end
  end

  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;

  // ---------------------------------------------------------------------------
  // Period counter and measurement
  // ---------------------------------------------------------------------------
  // Saturating increment; also the period reported at a rise (cnt counts from 0).
  assign cnt_inc     = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
  assign timeout_hit = (cnt_q == TimeoutLast) && !rise_det;

  always_comb begin
    cnt_d          = cnt_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    overflow_d     = overflow_q;
    if (rise_det) begin
      cnt_d = '0;
      if (state_q == StArmed) begin
        period_d       = cnt_inc;
        period_valid_d = 1'b1;
        overflow_d     = (cnt_inc == CntMax);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign overflow     = overflow_q;

  // ---------------------------------------------------------------------------
  // Arm / stall tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StUnarmed;
    end else begin
      state_q <= state_d;
    end
  end

  // A rise always wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    if (rise_det) begin
      state_d = StArmed;
    end else if (timeout_hit) begin
      state_d = StStalled;
    end
  end

  assign stalled = (state_q == StStalled);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!resetn)
    !(rise_pulse && fall_pulse));

  a_valid_single: assert property (@(posedge clk) disable iff (!resetn)
    period_valid |=> !period_valid);

  a_valid_with_rise: assert property (@(posedge clk) disable iff (!resetn)
    period_valid |-> rise_pulse);

endmodule

// File: tb/tb_mfp_clock_edge_monitor.sv
// Directed bench for mfp_clock_edge_monitor: three instances cover the default-width main
// configuration, a narrow counter with short timeout, and a narrow counter that can saturate.
module tb_mfp_clock_edge_monitor;

  logic clk;
  logic resetn;

  // main instance: CNT_W 28, TIMEOUT 50
  logic        a_sig, a_rise, a_fall, a_sync, a_pv, a_ovf, a_stall;
  logic [27:0] a_period;
  // narrow instance: CNT_W 4, TIMEOUT 14
  logic        b_sig, b_rise, b_fall, b_sync, b_pv, b_ovf, b_stall;
  logic [3:0]  b_period;
  // saturating instance: CNT_W 4, TIMEOUT 16 (timeout only at saturation, so overflow is reachable)
  logic        c_sig, c_rise, c_fall, c_sync, c_pv, c_ovf, c_stall;
  logic [3:0]  c_period;

  mfp_clock_edge_monitor #(.SYNC_STAGES(2), .CNT_W(28), .TIMEOUT(50)) u_a (
    .clk(clk), .resetn(resetn), .sig_async(a_sig), .rise_pulse(a_rise), .fall_pulse(a_fall),
    .sig_sync(a_sync), .period(a_period), .period_valid(a_pv), .overflow(a_ovf),
    .stalled(a_stall)
  );

  mfp_clock_edge_monitor #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT(14)) u_b (
    .clk(clk), .resetn(resetn), .sig_async(b_sig), .rise_pulse(b_rise), .fall_pulse(b_fall),
    .sig_sync(b_sync), .period(b_period), .period_valid(b_pv), .overflow(b_ovf),
    .stalled(b_stall)
  );

  mfp_clock_edge_monitor #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT(16)) u_c (
    .clk(clk), .resetn(resetn), .sig_async(c_sig), .rise_pulse(c_rise), .fall_pulse(c_fall),
    .sig_sync(c_sync), .period(c_period), .period_valid(c_pv), .overflow(c_ovf),
    .stalled(c_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // main instance monitor state
  int          a_n_rise, a_n_fall, a_n_pv, a_n_bad, a_n_both, a_gap_min, a_gap_max;
  int          a_last_rise_cyc;
  int          a_prev_sum;
  logic [27:0] a_last_period;
  logic [27:0] a_q[$];
  // narrow instances monitor state
  int          b_n_rise, b_n_pv, b_n_bad, b_n_stall;
  logic        b_stall_prev;
  logic [3:0]  b_exp;
  logic        b_exp_ovf;
  int          c_n_rise, c_n_pv, c_n_bad;
  logic [3:0]  c_exp;
  logic        c_exp_ovf;

  // Advance one clock and record what the instances did in that cycle.
  task automatic tick();
    logic [27:0] exp_p;
    int gap;
    @(posedge clk);
    #1;
    cyc++;
    if (a_rise) begin
      a_n_rise++;
      a_last_rise_cyc = cyc;
    end
    if (a_fall) begin
      a_n_fall++;
      gap = cyc - a_last_rise_cyc;
      if (gap < a_gap_min) a_gap_min = gap;
      if (gap > a_gap_max) a_gap_max = gap;
    end
    if (a_rise && a_fall) a_n_both++;
    if (a_pv) begin
      a_n_pv++;
      a_last_period = a_period;
      if (!a_rise) a_n_bad++;
      if (a_q.size() == 0) a_n_bad++;
      else begin
        exp_p = a_q.pop_front();
        if (a_period !== exp_p) a_n_bad++;
      end
    end
    if (b_rise) b_n_rise++;
    if (b_pv) begin
      b_n_pv++;
      if (b_period !== b_exp || b_ovf !== b_exp_ovf) b_n_bad++;
    end
    if (b_stall && !b_stall_prev) b_n_stall++;
    b_stall_prev = b_stall;
    if (c_rise) c_n_rise++;
    if (c_pv) begin
      c_n_pv++;
      if (c_period !== c_exp || c_ovf !== c_exp_ovf) c_n_bad++;
    end
  endtask

  task automatic clear_a();
    a_n_rise = 0; a_n_fall = 0; a_n_pv = 0; a_n_bad = 0; a_n_both = 0;
    a_gap_min = 1000; a_gap_max = -1;
  endtask

  // Hold low long enough to stall, which leaves the instance unarmed.
  task automatic quiesce_a();
    a_sig = 1'b0;
    repeat (60) tick();
    a_q.delete();
    a_prev_sum = -1;
    clear_a();
  endtask

  task automatic drive_a(input int high, input int low);
    if (a_prev_sum > 0) a_q.push_back(28'(a_prev_sum));
    a_prev_sum = high + low;
    a_sig = 1'b1;
    repeat (high) tick();
    a_sig = 1'b0;
    repeat (low) tick();
  endtask

  task automatic drive_bc(input bit sel_c, input int high, input int low, input int n);
    repeat (n) begin
      if (sel_c) c_sig = 1'b1; else b_sig = 1'b1;
      repeat (high) tick();
      if (sel_c) c_sig = 1'b0; else b_sig = 1'b0;
      repeat (low) tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({a_rise, a_fall, a_sync, a_period, a_pv, a_ovf, a_stall} !== '0) begin
      failures++; $display("FAIL reset_a_outputs got=%h want=0",
        {a_rise, a_fall, a_sync, a_period, a_pv, a_ovf, a_stall}); end
    checks++; if ({b_rise, b_fall, b_sync, b_period, b_pv, b_ovf, b_stall,
                   c_rise, c_fall, c_sync, c_period, c_pv, c_ovf, c_stall} !== '0) begin
      failures++; $display("FAIL reset_bc_outputs got=nonzero want=0"); end
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    checks++; if ({a_rise, a_fall, a_pv, a_stall, a_period} !== '0) begin
      failures++; $display("FAIL reset_release_idle got=%h want=0",
        {a_rise, a_fall, a_pv, a_stall, a_period}); end
  endtask

  task automatic test_basic();
    quiesce_a();
    repeat (6) drive_a(2, 2);
    repeat (6) tick();
    checks++; if (a_n_rise != 6) begin failures++;
      $display("FAIL basic_rise_count got=%0d want=6", a_n_rise); end
    checks++; if (a_n_fall != 6) begin failures++;
      $display("FAIL basic_fall_count got=%0d want=6", a_n_fall); end
    checks++; if (a_n_pv != 5) begin failures++;
      $display("FAIL basic_pv_count got=%0d want=5", a_n_pv); end
    checks++; if (a_n_bad != 0) begin failures++;
      $display("FAIL basic_pv_values bad=%0d want=0", a_n_bad); end
    checks++; if (a_last_period !== 28'd4 || a_ovf !== 1'b0) begin failures++;
      $display("FAIL basic_period got=%0d ovf=%b want=4 ovf=0", a_last_period, a_ovf); end
    checks++; if (a_gap_min != 2 || a_gap_max != 2) begin failures++;
      $display("FAIL basic_fall_gap got=%0d..%0d want=2..2", a_gap_min, a_gap_max); end
  endtask

  task automatic test_latency();
    int k;
    quiesce_a();
    a_sig = 1'b1;
    k = cyc + 1;
    tick(); tick();
    checks++; if (a_rise !== 1'b0) begin failures++;
      $display("FAIL latency_early cyc=k+%0d got=%b want=0", cyc - k, a_rise); end
    tick();
    checks++; if (a_rise !== 1'b1) begin failures++;
      $display("FAIL latency_on cyc=k+%0d got=%b want=1", cyc - k, a_rise); end
    tick();
    checks++; if (a_rise !== 1'b0) begin failures++;
      $display("FAIL latency_single cyc=k+%0d got=%b want=0", cyc - k, a_rise); end
    a_sig = 1'b0;
    repeat (6) tick();
    a_prev_sum = 10;
  endtask

  task automatic test_stall();
    repeat (4) drive_a(5, 5);
    a_q.push_back(28'd10);
    a_sig = 1'b1;
    for (int i = 0; i < 200 && a_stall !== 1'b1; i++) tick();
    checks++; if (a_stall !== 1'b1) begin failures++;
      $display("FAIL stall_assert got=%b want=1", a_stall); end
    checks++; if (cyc - a_last_rise_cyc != 50) begin failures++;
      $display("FAIL stall_delay got=%0d want=50", cyc - a_last_rise_cyc); end
    a_prev_sum = -1;
    a_sig = 1'b0;
    repeat (5) tick();
    clear_a();
    drive_a(5, 5);
    checks++; if (a_stall !== 1'b0 || a_n_pv != 0) begin failures++;
      $display("FAIL stall_resume_first got stalled=%b pv=%0d want 0 0", a_stall, a_n_pv); end
    drive_a(5, 5);
    repeat (6) tick();
    checks++; if (a_n_pv != 1 || a_last_period !== 28'd10 || a_n_bad != 0) begin failures++;
      $display("FAIL stall_resume_period got pv=%0d period=%0d bad=%0d want 1 10 0",
        a_n_pv, a_last_period, a_n_bad); end
  endtask

  task automatic test_reset_mid();
    quiesce_a();
    repeat (4) drive_a(4, 4);
    checks++; if (a_n_pv != 3 || a_last_period !== 28'd8) begin failures++;
      $display("FAIL midreset_pre got pv=%0d period=%0d want 3 8", a_n_pv, a_last_period); end
    a_sig = 1'b1;
    tick(); tick();
    #2;
    resetn = 1'b0;
    #1;
    checks++; if ({a_rise, a_fall, a_sync, a_period, a_pv, a_ovf, a_stall} !== '0) begin
      failures++; $display("FAIL midreset_async got=%h want=0",
        {a_rise, a_fall, a_sync, a_period, a_pv, a_ovf, a_stall}); end
    a_sig = 1'b0;
    a_q.delete();
    a_prev_sum = -1;
    tick(); tick();
    resetn = 1'b1;
    tick();
    clear_a();
    drive_a(4, 4);
    checks++; if (a_n_rise != 1 || a_n_pv != 0) begin failures++;
      $display("FAIL midreset_arm got rise=%0d pv=%0d want 1 0", a_n_rise, a_n_pv); end
    repeat (2) drive_a(4, 4);
    repeat (6) tick();
    checks++; if (a_n_pv != 2 || a_last_period !== 28'd8 || a_n_bad != 0) begin failures++;
      $display("FAIL midreset_period got pv=%0d period=%0d bad=%0d want 2 8 0",
        a_n_pv, a_last_period, a_n_bad); end
  endtask

  task automatic test_narrow();
    // period 12
    b_sig = 1'b0; repeat (20) tick();
    b_n_rise = 0; b_n_pv = 0; b_n_bad = 0; b_exp = 4'd12; b_exp_ovf = 1'b0;
    drive_bc(1'b0, 6, 6, 4);
    repeat (6) tick();
    checks++; if (b_n_rise != 4 || b_n_pv != 3 || b_n_bad != 0) begin failures++;
      $display("FAIL narrow_p12 got rise=%0d pv=%0d bad=%0d want 4 3 0", b_n_rise, b_n_pv, b_n_bad); end
    checks++; if (b_period !== 4'd12 || b_ovf !== 1'b0) begin failures++;
      $display("FAIL narrow_p12_out got period=%0d ovf=%b want 12 0", b_period, b_ovf); end
    // period 14: rise lands on the timeout cycle and wins
    b_sig = 1'b0; repeat (20) tick();
    b_n_rise = 0; b_n_pv = 0; b_n_bad = 0; b_n_stall = 0; b_exp = 4'd14; b_exp_ovf = 1'b0;
    drive_bc(1'b0, 7, 7, 4);
    checks++; if (b_n_stall != 0) begin failures++;
      $display("FAIL narrow_p14_stall got=%0d want=0", b_n_stall); end
    repeat (6) tick();
    checks++; if (b_n_pv != 3 || b_n_bad != 0 || b_period !== 4'd14) begin failures++;
      $display("FAIL narrow_p14 got pv=%0d bad=%0d period=%0d want 3 0 14", b_n_pv, b_n_bad,
        b_period); end
    // period 15: timeout fires first, so every rise only re-arms
    b_sig = 1'b0; repeat (20) tick();
    b_n_rise = 0; b_n_pv = 0; b_n_stall = 0;
    drive_bc(1'b0, 8, 7, 4);
    checks++; if (b_n_rise != 4 || b_n_pv != 0) begin failures++;
      $display("FAIL narrow_p15 got rise=%0d pv=%0d want 4 0", b_n_rise, b_n_pv); end
    checks++; if (b_n_stall < 3) begin failures++;
      $display("FAIL narrow_p15_stall got=%0d want>=3", b_n_stall); end
  endtask

  task automatic test_overflow();
    c_sig = 1'b0; repeat (20) tick();
    c_n_rise = 0; c_n_pv = 0; c_n_bad = 0; c_exp = 4'd15; c_exp_ovf = 1'b1;
    drive_bc(1'b1, 8, 7, 4);
    repeat (6) tick();
    checks++; if (c_n_pv != 3 || c_n_bad != 0 || c_period !== 4'd15 || c_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_p15 got pv=%0d bad=%0d period=%0d ovf=%b want 3 0 15 1",
        c_n_pv, c_n_bad, c_period, c_ovf); end
    c_sig = 1'b0; repeat (20) tick();
    c_n_pv = 0; c_n_bad = 0;
    drive_bc(1'b1, 8, 8, 4);
    repeat (6) tick();
    checks++; if (c_n_pv != 3 || c_n_bad != 0 || c_period !== 4'd15 || c_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_p16_sat got pv=%0d bad=%0d period=%0d ovf=%b want 3 0 15 1",
        c_n_pv, c_n_bad, c_period, c_ovf); end
    c_sig = 1'b0; repeat (20) tick();
    c_n_pv = 0; c_n_bad = 0; c_exp = 4'd12; c_exp_ovf = 1'b0;
    drive_bc(1'b1, 6, 6, 4);
    repeat (6) tick();
    checks++; if (c_n_pv != 3 || c_n_bad != 0 || c_ovf !== 1'b0) begin failures++;
      $display("FAIL ovf_clear got pv=%0d bad=%0d ovf=%b want 3 0 0", c_n_pv, c_n_bad, c_ovf); end
  endtask

  task automatic test_random();
    int h, l;
    quiesce_a();
    for (int i = 0; i < 500; i++) begin
      h = $urandom_range(20, 2);
      l = $urandom_range(20, 2);
      drive_a(h, l);
    end
    repeat (6) tick();
    checks++; if (a_n_rise != 500 || a_n_fall != 500) begin failures++;
      $display("FAIL random_strobes got rise=%0d fall=%0d want 500 500", a_n_rise, a_n_fall); end
    checks++; if (a_n_pv != 499 || a_n_bad != 0) begin failures++;
      $display("FAIL random_periods got pv=%0d bad=%0d want 499 0", a_n_pv, a_n_bad); end
    checks++; if (a_n_both != 0 || a_q.size() != 0) begin failures++;
      $display("FAIL random_misc got both=%0d pending=%0d want 0 0", a_n_both, a_q.size()); end
  endtask

  initial begin
    resetn = 1'b0;
    a_sig = 1'b0; b_sig = 1'b0; c_sig = 1'b0;
    a_prev_sum = -1; a_last_rise_cyc = 0; a_last_period = '0;
    b_stall_prev = 1'b0; b_exp = '0; b_exp_ovf = 1'b0; c_exp = '0; c_exp_ovf = 1'b0;
    b_n_rise = 0; b_n_pv = 0; b_n_bad = 0; b_n_stall = 0;
    c_n_rise = 0; c_n_pv = 0; c_n_bad = 0;
    clear_a();
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_reset_mid();
    test_narrow();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
